// File: rtl/operand_fetch.sv
// Operand fetch: walks the requested operand slots in ascending order and
// reads each one from a register bank over a toggle-trigger / ready-level
// handshake. The bank's ready level is asynchronous, so it is synchronised.
// After each toggle, ready is ignored for GUARD cycles. This covers a stale
// ready level left over from the previous read.
module operand_fetch #(
  parameter int GUARD   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_mask,
  input  logic [11:0] req_addr,
  output logic        rd_trig,
  output logic [3:0]  rd_addr,
  input  logic        rd_ready,
  input  logic [31:0] rd_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [95:0] op_data,
  output logic        op_err
);

  typedef enum logic [2:0] {IDLE, SETUP, TRIG, GUARD_W, WAIT, NEXT, DONE} state_t;

  localparam logic [3:0] GUARD_LAST = 4'(GUARD - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  sync;
  logic        rdy_s;
  logic [2:0]  mask_l;
  logic [11:0] addr_l;
  logic [1:0]  slot;
  logic        more;
  logic [3:0]  g_cnt;
  logic [7:0]  to_cnt;
  logic [1:0]  first_slot;
  logic [1:0]  nxt_slot;
  logic        nxt_found;
  logic        wait_done;

  // Two-flop synchroniser for the bank's asynchronous ready level.
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], rd_ready};
  end

  assign rdy_s     = sync[1];
  assign wait_done = rdy_s || (to_cnt == TO_LAST);

  // Lowest set bit of the incoming mask, and the next set bit above the current slot.
  always_comb begin
    first_slot = 2'd0;
    nxt_found  = 1'b0;
    nxt_slot   = slot;
    for (int i = 2; i >= 0; i--) begin
      if (req_mask[i]) first_slot = 2'(i);
      if (mask_l[i] && (i > int'(slot))) begin
        nxt_found = 1'b1;
        nxt_slot  = 2'(i);
      end
    end
  end

  // Fetch sequencer. All outputs are registered here.
  // The slot advances on the capture/timeout edge itself. The NEXT cycle
  // therefore presents the new rd_addr one cycle ahead of the toggle, and
  // acts as the setup cycle for the following read. This keeps every read
  // at SETUP/NEXT + TRIG + GUARD + capture cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      mask_l    <= '0;
      addr_l    <= '0;
      slot      <= '0;
      more      <= 1'b0;
      g_cnt     <= '0;
      to_cnt    <= '0;
      rd_trig   <= 1'b0;
      rd_addr   <= '0;
      op_valid  <= 1'b0;
      op_data   <= '0;
      op_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            mask_l    <= req_mask;
            addr_l    <= req_addr;
            op_data   <= '0;
            op_err    <= 1'b0;
            slot      <= first_slot;
            rd_addr   <= req_addr[4*first_slot +: 4];
            if (req_mask == 3'b000) begin
              op_valid <= 1'b1;
              state    <= DONE;
            end else begin
              state <= SETUP;
            end
          end
        end
        SETUP: state <= TRIG;
        TRIG: begin
          rd_trig <= ~rd_trig;
          g_cnt   <= '0;
          to_cnt  <= '0;
          state   <= GUARD_W;
        end
        GUARD_W: begin
          if (g_cnt == GUARD_LAST) state <= WAIT;
          else                     g_cnt <= g_cnt + 4'd1;
        end
        WAIT: begin
          if (wait_done) begin
            if (rdy_s) op_data[32*slot +: 32] <= rd_data;
            else       op_err <= 1'b1;
            slot <= nxt_slot;
            more <= nxt_found;
            if (nxt_found) rd_addr <= addr_l[4*nxt_slot +: 4];
            state <= NEXT;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        NEXT: begin
          if (more) begin
            state <= TRIG;
          end else begin
            op_valid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (op_ready) begin
            op_valid  <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a table of fetch vectors run against a
// behavioural register bank, plus hand sequences for back-pressure and
// mid-read reset.
module tb_operand_fetch;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_mask;
  logic [11:0] req_addr;
  logic        rd_trig, rd_ready;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        op_valid, op_ready, op_err;
  logic [95:0] op_data;

  operand_fetch #(.GUARD(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mask(req_mask), .req_addr(req_addr),
    .rd_trig(rd_trig), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_data(rd_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_data(op_data), .op_err(op_err)
  );

  typedef struct {
    logic [2:0]  mask;
    logic [11:0] addr;
    int          lat;      // cycles from toggle to ready rise
    int          drop;     // cycles from toggle to ready fall
    bit          dead;     // bank never answers
    logic [95:0] exp_data;
    logic        exp_err;
    int          exp_cyc;  // cycles from acceptance edge to op_valid, -1 = unchecked
  } vec_t;

  int         errs, checks, tcount;
  logic [3:0] alog[$];
  bit         bank_en, bank_dead;
  int         bank_lat, bank_drop;
  vec_t       vecs[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural bank: each trigger toggle logs the address, then ready drops
  // and later rises with data = address nibble replicated.
  initial begin : bank
    logic       last;
    bit         pend;
    int         k;
    logic [3:0] a;
    last = 1'b0; pend = 1'b0; k = 0; a = 4'h0;
    forever begin
      @(posedge clk); #1;
      if (!bank_en) begin
        last = rd_trig;
        pend = 1'b0;
      end else begin
        if (rd_trig !== last) begin
          last = rd_trig; pend = 1'b1; k = 0; a = rd_addr;
          tcount++;
          alog.push_back(rd_addr);
        end
        if (pend) begin
          if (k == bank_drop) rd_ready = 1'b0;
          if (k == bank_lat) begin
            if (!bank_dead) begin
              rd_data  = {8{a}};
              rd_ready = 1'b1;
            end
            pend = 1'b0;
          end
          k++;
        end
      end
    end
  end

  task automatic accept(input logic [2:0] m, input logic [11:0] a);
    int n;
    req_valid = 1'b1; req_mask = m; req_addr = a;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_ready before accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    chk("op_valid after handshake", op_valid, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, t0, j;
    logic [11:0] av;
    bank_lat = v.lat; bank_drop = v.drop; bank_dead = v.dead;
    alog.delete();
    t0 = tcount;
    accept(v.mask, v.addr);
    cyc = 0;
    while (!op_valid && cyc < 400) begin @(posedge clk); #1; cyc++; end
    chk($sformatf("v%0d op_valid", idx), op_valid, 1'b1);
    if (v.exp_cyc >= 0) chk($sformatf("v%0d latency", idx), cyc, v.exp_cyc);
    chk($sformatf("v%0d op_data", idx), op_data, v.exp_data);
    chk($sformatf("v%0d op_err", idx), op_err, v.exp_err);
    chk($sformatf("v%0d toggles", idx), tcount - t0, $countones(v.mask));
    chk($sformatf("v%0d rd_trig parity", idx), rd_trig, tcount % 2);
    av = v.addr; j = 0;
    for (int s = 0; s < 3; s++) begin
      if (v.mask[s] && alog.size() > j) begin
        chk($sformatf("v%0d rd_addr slot%0d", idx, s), alog[j], av[4*s +: 4]);
        j++;
      end
    end
    handshake();
  endtask

  initial begin
    int t0, n;
    errs = 0; checks = 0; tcount = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_mask = '0; req_addr = '0;
    op_ready = 1'b0; rd_ready = 1'b0; rd_data = '0;
    bank_en = 1'b0; bank_dead = 1'b0; bank_lat = 3; bank_drop = 0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst req_ready", req_ready, 1'b0);
    chk("rst op_valid", op_valid, 1'b0);
    chk("rst rd_trig", rd_trig, 1'b0);
    chk("rst rd_addr", rd_addr, 4'h0);
    chk("rst op_data", op_data, 96'h0);
    chk("rst op_err", op_err, 1'b0);
    rst_n = 1'b1;
    bank_en = 1'b1;
    @(posedge clk); #1;
    chk("req_ready after release", req_ready, 1'b1);

    //           mask    addr    lat drop dead exp_data                                     err  cyc
    vecs[0] = '{3'b011, 12'h021, 3, 0,  0, {32'h0, 32'h22222222, 32'h11111111},          1'b0, -1};
    vecs[1] = '{3'b000, 12'h021, 3, 0,  0, 96'h0,                                        1'b0, 0};
    vecs[2] = '{3'b111, 12'h753, 0, 99, 0, {32'h77777777, 32'h55555555, 32'h33333333},   1'b0, 22};
    vecs[3] = '{3'b011, 12'h0A5, 4, 2,  0, {32'h0, 32'hAAAAAAAA, 32'h55555555},          1'b0, -1};
    vecs[4] = '{3'b100, 12'hC00, 0, 0,  1, 96'h0,                                        1'b1, 262};
    vecs[5] = '{3'b101, 12'h909, 1, 0,  0, {32'h99999999, 32'h0, 32'h99999999},          1'b0, 15};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-pressure: result held in DONE, new request ignored until after handshake
    bank_lat = 0; bank_drop = 99; bank_dead = 1'b0;
    accept(3'b111, 12'h1F6);
    n = 0;
    while (!op_valid && n < 400) begin @(posedge clk); #1; n++; end
    chk("bp op_valid", op_valid, 1'b1);
    req_valid = 1'b1; req_mask = 3'b000; req_addr = 12'h0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold op_valid c%0d", c), op_valid, 1'b1);
      chk($sformatf("bp hold op_data c%0d", c), op_data, {32'h11111111, 32'hFFFFFFFF, 32'h66666666});
      chk($sformatf("bp hold req_ready c%0d", c), req_ready, 1'b0);
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    chk("bp idle op_valid", op_valid, 1'b0);
    chk("bp idle req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp new op_valid", op_valid, 1'b1);
    chk("bp new op_data", op_data, 96'h0);
    handshake();

    // Reset during WAIT of the second read
    bank_lat = 3; bank_drop = 0; bank_dead = 1'b0;
    t0 = tcount;
    accept(3'b011, 12'h0B3);
    n = 0;
    while (tcount < t0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
    bank_dead = 1'b1;
    chk("mid toggles", tcount - t0, 2);
    repeat (6) @(posedge clk); #1;
    chk("mid rd_trig before reset", rd_trig, tcount % 2);
    chk("mid op_valid before reset", op_valid, 1'b0);
    bank_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid rst rd_trig", rd_trig, 1'b0);
    chk("mid rst rd_addr", rd_addr, 4'h0);
    chk("mid rst op_valid", op_valid, 1'b0);
    chk("mid rst op_data", op_data, 96'h0);
    chk("mid rst op_err", op_err, 1'b0);
    chk("mid rst req_ready", req_ready, 1'b0);
    rst_n = 1'b1;
    rd_data = 32'hDEADBEEF;
    rd_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("late ready rd_trig", rd_trig, 1'b0);
    chk("late ready op_valid", op_valid, 1'b0);
    chk("late ready op_data", op_data, 96'h0);
    chk("late ready req_ready", req_ready, 1'b1);

    // Recovery read after the abort
    tcount = 0;
    bank_dead = 1'b0;
    bank_en = 1'b1;
    run_vec('{3'b010, 12'h040, 2, 0, 0, {32'h0, 32'h44444444, 32'h0}, 1'b0, -1}, 6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter GUARD, default 4: cycles after each trigger toggle during which rd_ready is ignored (range 2..15).
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for rd_ready per read (range 8..255).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 req_valid  input  1  decoder has an operand request.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_mask  input  3  bit i set: read operand i (i = 0 Rn, 1 Rm, 2 Rs).
REQ-008 req_addr  input  12  register numbers; operand i at bits [4i+3:4i].
REQ-009 rd_trig  output  1  register-bank read trigger; each toggle (either edge) is one read request.
REQ-010 rd_addr  output  4  register-bank read address.
REQ-011 rd_ready  input  1  register-bank read-done level; asynchronous to clk.
REQ-012 rd_data  input  32  register-bank read data; valid while synchronised rd_ready = 1 after guard.
REQ-013 op_valid  output  1  operand set available.
REQ-014 op_ready  input  1  issue stage consumes the operand set.
REQ-015 op_data  output  96  operand i at bits [32i+31:32i]; unread slots are 0.
REQ-016 op_err  output  1  a read timed out in this operand set; qualified by op_valid.

Function
REQ-017 rd_ready passes through a 2-flop synchroniser; "rdy_s" below refers to the synchronised value.
REQ-018 States: IDLE, SETUP, TRIG, GUARD_W, WAIT, NEXT, DONE.
REQ-019 IDLE: req_ready = 1; on req_valid, latch req_mask/req_addr and clear op_data and op_err; if the mask is 000, go to DONE, otherwise go to SETUP with the slot index set to the lowest set mask bit.
REQ-020 SETUP: drive rd_addr = the slot address for one cycle before any toggle, then go to TRIG.
REQ-021 TRIG: invert rd_trig (registered), clear the guard and timeout counters, then go to GUARD_W.
REQ-022 rd_addr is held constant from SETUP through the capture of that slot.
REQ-023 GUARD_W: count GUARD cycles with rdy_s ignored, then go to WAIT.
REQ-024 WAIT: when rdy_s = 1, capture rd_data into the current slot and go to NEXT; the capture happens on the same edge at which rdy_s = 1 is sampled.
REQ-025 WAIT: if the timeout counter reaches TIMEOUT with rdy_s = 0, the slot holds 0, op_err is set, and the state goes to NEXT.
REQ-026 NEXT: advance to the next higher set mask bit and go to SETUP; if no set bit remains, go to DONE.
REQ-027 DONE: op_valid = 1; on op_ready, go to IDLE.
REQ-028 op_data and op_err are stable while op_valid = 1 and op_ready = 0.
REQ-029 req_ready = 1 only in IDLE; a new request is not accepted in the same cycle as the op_ready handshake (one IDLE cycle minimum).
REQ-030 Reads run in ascending slot order; one toggle per set mask bit; duplicate addresses are each read separately.
REQ-031 Minimum latency per read is 1 (SETUP) + 1 (TRIG) + GUARD + 1 (capture) cycles, excluding synchroniser delay.
REQ-032 A 3-read set with GUARD = 4 and rd_ready already high completes with op_valid asserted 22 cycles after acceptance (3×7 cycles + NEXT→DONE).
REQ-033 rd_trig parity counts toggles: after N completed reads since reset, rd_trig = N mod 2.
REQ-034 req_valid, req_mask and req_addr are ignored outside IDLE.

Reset
REQ-035 rst_n = 0 at a rising edge forces: state IDLE, rd_trig 0, rd_addr 0, op_valid 0, op_data 0, op_err 0, req_ready 0 during reset and 1 on the first cycle after release, synchroniser flops 0, all counters 0.
REQ-036 Reset mid-operation aborts the sequence with no further toggle; a read in flight at the bank is abandoned and its result is not captured.

Verification
REQ-037 Mask 011, addr Rn = 1, Rm = 2, bank model returns 0x11111111 / 0x22222222 three cycles after each toggle -> two rd_trig toggles with rd_addr 1 then 2, op_data = {0, 0x22222222, 0x11111111}, op_err = 0.
REQ-038 Mask 000 -> no toggle, op_valid on the cycle after acceptance, op_data = 0.
REQ-039 Mask 100, bank keeps rd_ready low -> op_valid after GUARD + TIMEOUT (+ setup) cycles, slot 2 = 0, op_err = 1, rd_trig toggled once.
REQ-040 Mask 111, op_ready held low for 10 cycles in DONE -> op_data/op_valid stable, req_ready = 0, new req_valid ignored; accepted only after the handshake and one IDLE cycle.
REQ-041 rst_n pulsed low during WAIT of slot 1 -> next cycle all outputs at reset values, rd_trig = 0, late rd_ready rise ignored.
REQ-042 Bank asserts rd_ready during GUARD_W (stale high from previous read) -> not captured early; capture occurs only in WAIT with the correct data.
